// File: rtl/uart_packet_mux.sv
// uart_packet_mux: frames channel changes and RX echoes as UART packets.
// Optional checksum trailer byte: define UART_PACKET_MUX_CHECKSUM_EN.
module uart_packet_mux #(
    parameter int         NCH      = 2,
    parameter int         CH_W     = 18,
    parameter int         RX_DEPTH = 16,
    parameter logic [7:0] ECHO_CMD = 8'h04,
    parameter int         ECHO_MAX = 4,
    parameter logic [7:0] SYNC     = 8'hFF
) (
    input  logic                        CLOCK_50,
    input  logic                        RESET,
    input  logic [NCH*CH_W-1:0]         CH_IN,
    output logic [7:0]                  TX_DATA,
    output logic                        TX_START,
    input  logic                        TX_BUSY,
    input  logic [7:0]                  RX_DATA,
    input  logic                        RX_RECV,
    output logic                        BUSY,
    output logic [$clog2(RX_DEPTH):0]   RX_LEVEL,
    output logic                        OVERRUN
);

    localparam int LEN_CH = (CH_W + 7) / 8;
    localparam int SHW    = LEN_CH * 8;
    localparam int AW     = $clog2(RX_DEPTH);
    localparam int LW     = AW + 1;
    localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [LW-1:0] DEPTH_L = LW'(RX_DEPTH);
    localparam logic [LW-1:0] EMAX_L  = LW'(ECHO_MAX);
    localparam logic [7:0]    LEN_L   = 8'(LEN_CH);

`ifdef UART_PACKET_MUX_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_SYNC, ST_CMD, ST_LEN,
        ST_DATA, ST_SUM, ST_ACK, ST_DRAIN
    } state_t;
    localparam state_t ST_END = ST_SUM;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_SYNC, ST_CMD, ST_LEN,
        ST_DATA, ST_ACK, ST_DRAIN
    } state_t;
    localparam state_t ST_END = ST_IDLE;
`endif

    state_t            state_q, nxt_q;
    logic [7:0]        tx_data_q;
    logic              tx_start_q;
    logic              busy_q;
    logic              overrun_q;
    logic [AW-1:0]     wr_q, rd_q;
    logic [LW-1:0]     lvl_q, lvl_d;
    logic [CH_W-1:0]   last_q [NCH];
    logic [CW-1:0]     ptr_q;
    logic [SHW-1:0]    shift_q;
    logic              echo_q;
    logic [7:0]        cmd_q, len_q, cnt_q;
    logic [7:0]        mem_q [RX_DEPTH];
`ifdef UART_PACKET_MUX_CHECKSUM_EN
    logic [7:0]        sum_q;
`endif

    logic [NCH-1:0]    pend;
    logic              hit;
    logic [CW-1:0]     sel;
    logic [CH_W-1:0]   sel_val;
    int                idx;
    logic              full, push, pop;
    logic [LW-1:0]     elen;
    logic [7:0]        byte_d;

    always_comb begin
        pend = '0;
        for (int i = 0; i < NCH; i++)
            pend[i] = CH_IN[i*CH_W +: CH_W] != last_q[i];
    end

    // Round-robin scan starting at ptr_q, the slot after the last one served.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        idx = 0;
        for (int k = 0; k < NCH; k++) begin
            idx = (int'(ptr_q) + k) % NCH;
            if (!hit && pend[CW'(idx)]) begin
                hit = 1'b1;
                sel = CW'(idx);
            end
        end
    end

    always_comb begin
        sel_val = '0;
        for (int i = 0; i < NCH; i++)
            if (CW'(i) == sel)
                sel_val = CH_IN[i*CH_W +: CH_W];
    end

    assign full   = lvl_q == DEPTH_L;
    assign push   = RX_RECV && !full;
    assign pop    = (state_q == ST_DATA) && echo_q && !TX_BUSY;
    assign elen   = (lvl_q < EMAX_L) ? lvl_q : EMAX_L;
    assign byte_d = echo_q ? mem_q[rd_q] : shift_q[7:0];

    always_comb begin
        lvl_d = lvl_q;
        if (push && !pop)
            lvl_d = lvl_q + 1'b1;
        else if (pop && !push)
            lvl_d = lvl_q - 1'b1;
    end

    always_ff @(posedge CLOCK_50) begin
        if (push)
            mem_q[wr_q] <= RX_DATA;
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            wr_q      <= '0;
            rd_q      <= '0;
            lvl_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            lvl_q <= lvl_d;
            if (push)
                wr_q <= wr_q + 1'b1;
            if (pop)
                rd_q <= rd_q + 1'b1;
            if (RX_RECV && full)
                overrun_q <= 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            nxt_q      <= ST_IDLE;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            ptr_q      <= '0;
            shift_q    <= '0;
            echo_q     <= 1'b0;
            cmd_q      <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < NCH; i++)
                last_q[i] <= '0;
`ifdef UART_PACKET_MUX_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            tx_start_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (lvl_q != '0) begin
                        echo_q  <= 1'b1;
                        cmd_q   <= ECHO_CMD;
                        len_q   <= 8'(elen);
                        cnt_q   <= 8'(elen);
                        busy_q  <= 1'b1;
                        state_q <= ST_SYNC;
`ifdef UART_PACKET_MUX_CHECKSUM_EN
                        sum_q   <= ECHO_CMD + 8'(elen);
`endif
                    end else if (hit) begin
                        echo_q      <= 1'b0;
                        cmd_q       <= 8'(sel);
                        len_q       <= LEN_L;
                        cnt_q       <= LEN_L;
                        shift_q     <= SHW'(sel_val);
                        last_q[sel] <= sel_val;
                        ptr_q       <= CW'((int'(sel) + 1) % NCH);
                        busy_q      <= 1'b1;
                        state_q     <= ST_SYNC;
`ifdef UART_PACKET_MUX_CHECKSUM_EN
                        sum_q       <= 8'(sel) + LEN_L;
`endif
                    end
                end
                ST_SYNC: begin
                    if (!TX_BUSY) begin
                        tx_data_q  <= SYNC;
                        tx_start_q <= 1'b1;
                        nxt_q      <= ST_CMD;
                        state_q    <= ST_ACK;
                    end
                end
                ST_CMD: begin
                    if (!TX_BUSY) begin
                        tx_data_q  <= cmd_q;
                        tx_start_q <= 1'b1;
                        nxt_q      <= ST_LEN;
                        state_q    <= ST_ACK;
                    end
                end
                ST_LEN: begin
                    if (!TX_BUSY) begin
                        tx_data_q  <= len_q;
                        tx_start_q <= 1'b1;
                        nxt_q      <= ST_DATA;
                        state_q    <= ST_ACK;
                    end
                end
                ST_DATA: begin
                    if (!TX_BUSY) begin
                        tx_data_q  <= byte_d;
                        tx_start_q <= 1'b1;
                        shift_q    <= shift_q >> 8;
                        cnt_q      <= cnt_q - 1'b1;
                        nxt_q      <= (cnt_q == 8'd1) ? ST_END : ST_DATA;
                        state_q    <= ST_ACK;
`ifdef UART_PACKET_MUX_CHECKSUM_EN
                        sum_q      <= sum_q + byte_d;
`endif
                    end
                end
`ifdef UART_PACKET_MUX_CHECKSUM_EN
                ST_SUM: begin
                    if (!TX_BUSY) begin
                        tx_data_q  <= sum_q;
                        tx_start_q <= 1'b1;
                        nxt_q      <= ST_IDLE;
                        state_q    <= ST_ACK;
                    end
                end
`endif
                ST_ACK: begin
                    if (TX_BUSY)
                        state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!TX_BUSY) begin
                        if (nxt_q == ST_IDLE)
                            busy_q <= 1'b0;
                        state_q <= nxt_q;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign TX_DATA  = tx_data_q;
    assign TX_START = tx_start_q;
    assign BUSY     = busy_q;
    assign RX_LEVEL = lvl_q;
    assign OVERRUN  = overrun_q;

endmodule

// File: tb/tb_uart_packet_mux.sv
// Directed bench for uart_packet_mux with a behavioural uart transmitter.
// Handles the UART_PACKET_MUX_CHECKSUM_EN build by appending the trailer.
`timescale 1ns/1ps
module tb_uart_packet_mux;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic [35:0] ch_in;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_recv;
    logic        busy;
    logic [4:0]  rx_level;
    logic        overrun;

    logic [17:0] c0, c1;
    int          n_vec = 0;
    int          n_bad = 0;
    int          hold = 3;
    int          bcnt = 0;
    int          start_busy = 0;
    int          start_idle = 0;
    bq_t         rxq;

    assign ch_in = {c1, c0};

    always #5 clk = ~clk;

    uart_packet_mux dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .CH_IN    (ch_in),
        .TX_DATA  (tx_data),
        .TX_START (tx_start),
        .TX_BUSY  (tx_busy),
        .RX_DATA  (rx_data),
        .RX_RECV  (rx_recv),
        .BUSY     (busy),
        .RX_LEVEL (rx_level),
        .OVERRUN  (overrun)
    );

    // uart transmitter model: busy for `hold` cycles after each strobe
    always @(negedge clk) begin
        if (rst) begin
            bcnt    = 0;
            tx_busy = 1'b0;
        end else if (tx_start) begin
            if (tx_busy)
                start_busy++;
            if (!busy)
                start_idle++;
            rxq.push_back(tx_data);
            bcnt    = hold;
            tx_busy = 1'b1;
        end else if (bcnt > 0) begin
            bcnt--;
            if (bcnt == 0)
                tx_busy = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic wait_bytes(input int n);
        int t = 0;
        while (rxq.size() < n && t < 20000) begin
            @(posedge clk);
            t++;
        end
    endtask

    task automatic expect_pkt(input string tag, input bq_t e);
        logic [7:0] got;
        wait_bytes(e.size());
        foreach (e[i]) begin
            if (rxq.size() > 0)
                got = rxq.pop_front();
            else
                got = 8'hxx;
            chk($sformatf("%s[%0d]", tag, i), 32'(got), 32'(e[i]));
        end
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while (busy && t < 20000) begin
            @(posedge clk);
            t++;
        end
        cyc(8);
        @(negedge clk);
        chk({tag, " busy"}, 32'(busy), 32'(0));
        chk({tag, " extra bytes"}, 32'(rxq.size()), 32'(0));
    endtask

    task automatic rx_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_recv = 1'b1;
        @(negedge clk);
        rx_recv = 1'b0;
    endtask

    function automatic bq_t d3(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2);
        bq_t r;
        r.push_back(b0);
        r.push_back(b1);
        r.push_back(b2);
        return r;
    endfunction

    function automatic bq_t seq(input logic [7:0] first, input int n);
        bq_t r;
        for (int i = 0; i < n; i++)
            r.push_back(first + 8'(i));
        return r;
    endfunction

    function automatic bq_t pkt(input logic [7:0] cmd, input bq_t d);
        bq_t r;
`ifdef UART_PACKET_MUX_CHECKSUM_EN
        logic [7:0] s;
        s = cmd + 8'(d.size());
        foreach (d[i])
            s = s + d[i];
`endif
        r.push_back(8'hFF);
        r.push_back(cmd);
        r.push_back(8'(d.size()));
        foreach (d[i])
            r.push_back(d[i]);
`ifdef UART_PACKET_MUX_CHECKSUM_EN
        r.push_back(s);
`endif
        return r;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bq_t e;
        int  t;
        rst     = 1'b1;
        c0      = '0;
        c1      = '0;
        rx_data = '0;
        rx_recv = 1'b0;
        cyc(3);
        @(negedge clk);
        chk("rst tx_data",  32'(tx_data),  32'(0));
        chk("rst tx_start", 32'(tx_start), 32'(0));
        chk("rst busy",     32'(busy),     32'(0));
        chk("rst overrun",  32'(overrun),  32'(0));
        chk("rst level",    32'(rx_level), 32'(0));
        rst = 1'b0;
        wait_idle("post-rst");

        // single channel change
        c1 = 18'h2A5C3;
        e  = {};
        e.push_back(8'hFF); e.push_back(8'h01); e.push_back(8'h03);
        e.push_back(8'hC3); e.push_back(8'hA5); e.push_back(8'h02);
`ifdef UART_PACKET_MUX_CHECKSUM_EN
        e.push_back(8'h6E);
`endif
        expect_pkt("ch1 2A5C3", e);
        wait_idle("t1");

        // simultaneous change, then both change again mid-packet
        c0 = 18'h3FFFF;
        c1 = 18'h00100;
        wait_bytes(1);
        @(negedge clk);
        c0 = 18'h12345;
        c1 = 18'h0ABCD;
        expect_pkt("rr ch0", pkt(8'h00, d3(8'hFF, 8'hFF, 8'h03)));
        expect_pkt("rr ch1", pkt(8'h01, d3(8'hCD, 8'hAB, 8'h00)));
        expect_pkt("rr ch0b", pkt(8'h00, d3(8'h45, 8'h23, 8'h01)));
        wait_idle("t2");

        // six RX bytes queued behind a channel packet
        c1 = 18'h00007;
        wait_bytes(1);
        for (int b = 8'h10; b <= 8'h15; b++)
            rx_byte(8'(b));
        @(negedge clk);
        chk("echo level 6",   32'(rx_level), 32'(6));
        chk("echo overrun 0", 32'(overrun),  32'(0));
        expect_pkt("echo ch1", pkt(8'h01, d3(8'h07, 8'h00, 8'h00)));
        expect_pkt("echo a", pkt(8'h04, seq(8'h10, 4)));
        expect_pkt("echo b", pkt(8'h04, seq(8'h14, 2)));
        wait_idle("t3");
        chk("echo level 0", 32'(rx_level), 32'(0));

        // overrun with a slow transmitter
        hold = 40;
        c0   = 18'h00009;
        wait_bytes(1);
        for (int b = 0; b < 17; b++)
            rx_byte(8'(b));
        @(negedge clk);
        chk("ovr level 16", 32'(rx_level), 32'(16));
        chk("ovr flag",     32'(overrun),  32'(1));
        expect_pkt("ovr ch0", pkt(8'h00, d3(8'h09, 8'h00, 8'h00)));
        for (int p = 0; p < 4; p++)
            expect_pkt($sformatf("ovr echo%0d", p),
                       pkt(8'h04, seq(8'(4 * p), 4)));
        wait_idle("t4");
        chk("ovr sticky",  32'(overrun),  32'(1));
        chk("ovr level 0", 32'(rx_level), 32'(0));

        // reset while the first data strobe is high
        hold = 3;
        c1   = 18'h15555;
        t    = 0;
        do begin
            @(posedge clk);
            #1;
            t++;
        end while (!(tx_start && rxq.size() == 3) && t < 2000);
        chk("mid strobe seen", 32'(tx_start), 32'(1));
        rst = 1'b1;
        #1;
        chk("mid rst tx_start", 32'(tx_start), 32'(0));
        chk("mid rst busy",     32'(busy),     32'(0));
        chk("mid rst overrun",  32'(overrun),  32'(0));
        cyc(2);
        @(negedge clk);
        rxq.delete();
        rst = 1'b0;
        expect_pkt("rerep ch0", pkt(8'h00, d3(8'h09, 8'h00, 8'h00)));
        expect_pkt("rerep ch1", pkt(8'h01, d3(8'h55, 8'h55, 8'h01)));
        wait_idle("t5");

        chk("start while tx_busy", 32'(start_busy), 32'(0));
        chk("start while !BUSY",   32'(start_idle), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
